// File: rtl/msrv32_store_unit_if.sv
// Store-path signal bundle: decoder/execute request side plus AHB-lite data-memory write side.
// The store unit takes the slave view; whoever feeds requests and models the bus takes the master view.
interface msrv32_store_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // request side, from the pipeline
    logic              mem_wr_req_in;
    logic              trap_taken_in;
    logic [1:0]        funct3_in;
    logic [ADDR_W-1:0] iadder_in;
    logic [DATA_W-1:0] rs2_in;

    // bus side
    logic              ahb_ready_in;
    logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out;
    logic [DATA_W-1:0] ms_riscv32_mp_dmdata_out;
    logic [3:0]        ms_riscv32_mp_dmwr_mask_out;
    logic              ms_riscv32_mp_dmwr_req_out;
    logic [1:0]        ahb_htrans_out;

    // pipeline feedback
    logic              stall_out;
    logic              store_done_out;

    modport slave (
        input  mem_wr_req_in,
        input  trap_taken_in,
        input  funct3_in,
        input  iadder_in,
        input  rs2_in,
        input  ahb_ready_in,
        output ms_riscv32_mp_dmaddr_out,
        output ms_riscv32_mp_dmdata_out,
        output ms_riscv32_mp_dmwr_mask_out,
        output ms_riscv32_mp_dmwr_req_out,
        output ahb_htrans_out,
        output stall_out,
        output store_done_out
    );

    modport master (
        output mem_wr_req_in,
        output trap_taken_in,
        output funct3_in,
        output iadder_in,
        output rs2_in,
        output ahb_ready_in,
        input  ms_riscv32_mp_dmaddr_out,
        input  ms_riscv32_mp_dmdata_out,
        input  ms_riscv32_mp_dmwr_mask_out,
        input  ms_riscv32_mp_dmwr_req_out,
        input  ahb_htrans_out,
        input  stall_out,
        input  store_done_out
    );
endinterface

// File: rtl/msrv32_store_unit.sv
// Store unit: captures an accepted store, builds word address / lane data / byte mask,
// and holds a registered AHB-lite write request until HREADY, stalling the pipeline meanwhile.
module msrv32_store_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    msrv32_store_unit_if.slave   bus
);

    localparam int unsigned MASK_W = 4;

    localparam logic [1:0] F3_SB       = 2'b00;
    localparam logic [1:0] F3_SH       = 2'b01;
    localparam logic [1:0] F3_SW       = 2'b10;
    localparam logic [1:0] F3_RSVD     = 2'b11;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [MASK_W-1:0] mask_q,  mask_d;
    logic              req_q,   req_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              done_q,  done_d;

    logic              acc_c;
    logic [ADDR_W-1:0] word_addr_c;
    logic [DATA_W-1:0] lane_data_c;
    logic [MASK_W-1:0] lane_mask_c;

    // A new store may enter when idle, or when the in-flight one completes this cycle.
    assign acc_c = bus.mem_wr_req_in & ~bus.trap_taken_in & (bus.funct3_in != F3_RSVD)
                 & ((state_q == ST_IDLE) | ((state_q == ST_REQ) & bus.ahb_ready_in));

    assign word_addr_c = {bus.iadder_in[ADDR_W-1:2], 2'b00};

    // Replicate the source bytes across every lane so the mask alone selects the target bytes.
    always_comb begin
        lane_data_c = bus.rs2_in;
        lane_mask_c = 4'b1111;
        case (bus.funct3_in)
            F3_SB: begin
                lane_data_c = DATA_W'({4{bus.rs2_in[7:0]}});
                lane_mask_c = 4'b0001 << bus.iadder_in[1:0];
            end
            F3_SH: begin
                lane_data_c = DATA_W'({2{bus.rs2_in[15:0]}});
                lane_mask_c = bus.iadder_in[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
                lane_data_c = bus.rs2_in;
                lane_mask_c = 4'b1111;
            end
            default: begin
                lane_data_c = bus.rs2_in;
                lane_mask_c = 4'b0000;
            end
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mask_d   = mask_q;
        req_d    = req_q;
        htrans_d = htrans_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_c) begin
                    state_d  = ST_REQ;
                    addr_d   = word_addr_c;
                    data_d   = lane_data_c;
                    mask_d   = lane_mask_c;
                    req_d    = 1'b1;
                    htrans_d = HTRANS_NSEQ;
                end else begin
                    req_d    = 1'b0;
                    htrans_d = HTRANS_IDLE;
                    mask_d   = '0;
                end
            end
            ST_REQ: begin
                if (bus.ahb_ready_in) begin
                    done_d = 1'b1;
                    if (acc_c) begin
                        state_d  = ST_REQ;
                        addr_d   = word_addr_c;
                        data_d   = lane_data_c;
                        mask_d   = lane_mask_c;
                        req_d    = 1'b1;
                        htrans_d = HTRANS_NSEQ;
                    end else begin
                        state_d  = ST_IDLE;
                        req_d    = 1'b0;
                        htrans_d = HTRANS_IDLE;
                        mask_d   = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                req_d    = 1'b0;
                htrans_d = HTRANS_IDLE;
                mask_d   = '0;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            req_q    <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            req_q    <= req_d;
            htrans_q <= htrans_d;
            done_q   <= done_d;
        end
    end

    assign bus.ms_riscv32_mp_dmaddr_out    = addr_q;
    assign bus.ms_riscv32_mp_dmdata_out    = data_q;
    assign bus.ms_riscv32_mp_dmwr_mask_out = mask_q;
    assign bus.ms_riscv32_mp_dmwr_req_out  = req_q;
    assign bus.ahb_htrans_out              = htrans_q;
    assign bus.store_done_out              = done_q;

    // Only the pipeline hold sees HREADY combinationally; bus outputs stay registered.
    assign bus.stall_out = (state_q == ST_REQ) & ~bus.ahb_ready_in;

endmodule

// File: doc/msrv32_store_unit.md
Name: msrv32_store_unit

Overview:
- Downstream consumer of the decoder's store-request output; the store path between execute and the AHB-lite data-memory interface.
- On an accepted store it captures address, data and funct3, and builds word-aligned address, lane-shifted write data and byte-write mask.
- Drives a registered write request and holds it until the bus returns ready.
- Stalls the pipeline while a store is waiting on the bus.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data-bus width; fixed 4 byte lanes, other values unsupported.

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock, rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-high.
- mem_wr_req_in  input  1  store request from the decoder (already alignment-qualified).
- trap_taken_in  input  1  trap this cycle; blocks new acceptance.
- funct3_in  input  2  store size: 00 SB, 01 SH, 10 SW, 11 reserved.
- iadder_in  input  ADDR_W  effective address rs1+imm.
- rs2_in  input  DATA_W  store source data.
- ahb_ready_in  input  1  bus HREADY; transfer completes on a cycle it is 1.
- ms_riscv32_mp_dmaddr_out  output  ADDR_W  {addr[31:2],2'b00}.
- ms_riscv32_mp_dmdata_out  output  DATA_W  lane-aligned write data.
- ms_riscv32_mp_dmwr_mask_out  output  4  byte-write enables, bit i = byte lane i.
- ms_riscv32_mp_dmwr_req_out  output  1  write request valid.
- ahb_htrans_out  output  2  00 IDLE, 10 NONSEQ.
- stall_out  output  1  pipeline hold.
- store_done_out  output  1  one-cycle pulse on completion.

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0 (addr, data, mask, req, htrans=00, done).
- States: IDLE, REQ.
- Accept condition (acc): mem_wr_req_in & ~trap_taken_in & funct3_in!=11 & (state==IDLE | (state==REQ & ahb_ready_in)).
- On an acc edge, registered outputs are loaded next cycle:
  - dmaddr = {iadder_in[31:2],2'b00}; dmwr_req = 1; htrans = 10.
  - SB: data = {4{rs2_in[7:0]}}; mask = 4'b0001 << iadder_in[1:0].
  - SH: data = {2{rs2_in[15:0]}}; mask = iadder_in[1] ? 4'b1100 : 4'b0011.
  - SW: data = rs2_in; mask = 4'b1111.
- IDLE -> REQ on acc; otherwise stay IDLE with req/htrans/mask at 0 (addr/data hold last value).
- REQ, ahb_ready_in=0: hold all outputs unchanged, every bit stable.
- REQ, ahb_ready_in=1, no acc: store_done_out=1 for the next cycle; req/htrans/mask clear to 0; go IDLE.
- REQ, ahb_ready_in=1, with acc: back-to-back. store_done_out=1 next cycle, new transfer loaded in that same cycle, stay REQ. No IDLE bubble.
- stall_out (combinational) = (state==REQ) & ~ahb_ready_in. Latency: acc at edge N, req visible cycle N+1; with zero wait states done pulses at N+2 and stall never asserts.
- trap_taken_in in REQ does not abort: a bus transfer in flight is committed.
- funct3_in=11 with mem_wr_req_in=1: request ignored, no bus activity.
- iadder_in[1:0] misalignment is not rechecked; SH uses only bit 1 and SW ignores [1:0].
- No combinational path from ahb_ready_in to any bus output.

Test Plan:
- Reset mid-REQ with ahb_ready_in=0 -> all outputs 0 and state IDLE immediately; after release, req=0 until the next request.
- SB: iadder=0x1003, rs2=0xAABBCCDD, ready=1 -> next cycle addr=0x1000, data=0xDDDDDDDD, mask=1000, htrans=10; done pulses the cycle after.
- SH: iadder=0x2002, rs2=0x12345678, ready held 0 for 3 cycles -> addr=0x2000, data=0x56785678, mask=1100, outputs stable, stall_out=1 for 3 cycles; done on the cycle after ready rises.
- Back-to-back SW stores to 0x100 then 0x104 with ready=1 -> req stays 1 over consecutive cycles, addr 0x100 then 0x104, two done pulses, no IDLE gap.
- mem_wr_req_in=1 with trap_taken_in=1, and separately with funct3=11 -> req stays 0, no done pulse, stall_out=0.
- Trap asserted while in REQ with ready=0 -> transfer held; completes normally when ready=1.
